reset_sequencer: RTL and testbench

- Parametrised reset and watchdog controller for the super6502 top level. It replaces the fixed, single-shot button/CPU reset handling.
- Debounces the board button and holds every domain in reset for a minimum time.
- Releases NUM_CHANNELS reset domains in a staged order, e.g. SDRAM controller, then bus fabric, then CPU RESB.
- Optionally re-asserts all domains if the CPU stops showing bus activity (hang detection).

---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/button_debounce.sv | 54 +++++
 rtl/reset_sequencer.sv | 165 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and counter width helper for reset_sequencer
// Contents:
//    rst_state_t  - sequencer FSM state (S_HOLD, S_STAGE, S_RUN; value 3 unused)
//    cnt_width()  - bit width of a counter that counts 0..val-1, never narrower than 1
package reset_seq_pkg;

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_STAGE = 2'd1,
      S_RUN   = 2'd2
   } rst_state_t;

   function automatic int cnt_width(input int val);
      return (val < 2) ? 1 : $clog2(val);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser plus consecutive-sample debouncer
// Ports:
//    i_sysclk    - clock
//    i_rst_n     - asynchronous active-low reset; debounced output resets to 0 (pressed)
//    i_button_n  - raw active-low button, asynchronous to i_sysclk
//    o_btn_db    - debounced button level (1 = released)
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic i_sysclk,
   input  logic i_rst_n,
   input  logic i_button_n,
   output logic o_btn_db
);
   import reset_seq_pkg::*;

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);

   logic          sync1_q;
   logic          btn_s_q;
   logic          btn_db_q, btn_db_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;

   // The counter only advances while the synchronised level disagrees with the
   // debounced one; any agreeing sample restarts the count.
   always_comb begin
      btn_db_d = btn_db_q;
      db_cnt_d = '0;
      if (btn_s_q != btn_db_q) begin
         if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = btn_s_q;
         end else begin
            db_cnt_d = db_cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge i_sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q  <= 1'b0;
         btn_s_q  <= 1'b0;
         btn_db_q <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= i_button_n;
         btn_s_q  <= sync1_q;
         btn_db_q <= btn_db_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign o_btn_db = btn_db_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged multi-domain reset release with button debounce and watchdog
// Ports:
//    i_sysclk        - clock
//    i_rst_n         - asynchronous active-low power-on reset
//    i_button_n      - raw active-low board button
//    i_kick          - watchdog heartbeat, sampled in S_RUN
//    i_wdt_en        - watchdog enable level
//    o_rst_n         - per-domain active-low resets, bit 0 released first
//    o_all_released  - high only in S_RUN
//    o_wdt_fired     - sticky: last reset entry came from the watchdog
//    o_state         - current FSM state
module reset_sequencer #(
   parameter int NUM_CHANNELS    = 3,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 16,
   parameter int STAGE_DELAY     = 8,
   parameter int WDT_CYCLES      = 64
) (
   input  logic                    i_sysclk,
   input  logic                    i_rst_n,
   input  logic                    i_button_n,
   input  logic                    i_kick,
   input  logic                    i_wdt_en,
   output logic [NUM_CHANNELS-1:0] o_rst_n,
   output logic                    o_all_released,
   output logic                    o_wdt_fired,
   output logic [1:0]              o_state
);
   import reset_seq_pkg::*;

   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam int SW = cnt_width(STAGE_DELAY);
   localparam int IW = cnt_width(NUM_CHANNELS);
   localparam int WW = cnt_width(WDT_CYCLES);

   rst_state_t              state_q, state_d;
   logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
   logic [SW-1:0]           stage_cnt_q, stage_cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [WW-1:0]           wdt_cnt_q, wdt_cnt_d;
   logic [NUM_CHANNELS-1:0] rst_n_q, rst_n_d;
   logic                    released_q, released_d;
   logic                    fired_q, fired_d;
   logic                    btn_db;
   logic                    enter_hold;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_button_debounce (
      .i_sysclk   (i_sysclk),
      .i_rst_n    (i_rst_n),
      .i_button_n (i_button_n),
      .o_btn_db   (btn_db)
   );

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      stage_cnt_d = stage_cnt_q;
      idx_d       = idx_q;
      wdt_cnt_d   = '0;
      rst_n_d     = rst_n_q;
      released_d  = released_q;
      fired_d     = fired_q;
      enter_hold  = 1'b0;

      case (state_q)
         // The hold timer runs even while the button is still pressed so that
         // the power-on debounce overlaps the minimum hold time.
         S_HOLD: begin
            rst_n_d    = '0;
            released_d = 1'b0;
            if (hold_cnt_q != HW'(HOLD_CYCLES - 1)) begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end else if (btn_db) begin
               state_d     = S_STAGE;
               stage_cnt_d = '0;
               idx_d       = '0;
            end
         end

         S_STAGE: begin
            if (!btn_db) begin
               enter_hold = 1'b1;
            end else if (stage_cnt_q == SW'(STAGE_DELAY - 1)) begin
               for (int k = 0; k < NUM_CHANNELS; k++) begin
                  if (idx_q == IW'(k)) begin
                     rst_n_d[k] = 1'b1;
                  end
               end
               stage_cnt_d = '0;
               if (idx_q == IW'(NUM_CHANNELS - 1)) begin
                  state_d    = S_RUN;
                  released_d = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               stage_cnt_d = stage_cnt_q + SW'(1);
            end
         end

         // Button is checked first so a simultaneous press beats a watchdog expiry.
         S_RUN: begin
            if (!btn_db) begin
               enter_hold = 1'b1;
            end else if (i_kick || !i_wdt_en) begin
               wdt_cnt_d = '0;
            end else if (wdt_cnt_q == WW'(WDT_CYCLES - 1)) begin
               enter_hold = 1'b1;
               fired_d    = 1'b1;
            end else begin
               wdt_cnt_d = wdt_cnt_q + WW'(1);
            end
         end

         default: begin
            enter_hold = 1'b1;
         end
      endcase

      // A press always takes ownership of the reset cause.
      if (!btn_db) begin
         fired_d = 1'b0;
      end

      if (enter_hold) begin
         state_d     = S_HOLD;
         rst_n_d     = '0;
         released_d  = 1'b0;
         hold_cnt_d  = '0;
         stage_cnt_d = '0;
         idx_d       = '0;
         wdt_cnt_d   = '0;
      end
   end

   always_ff @(posedge i_sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_HOLD;
         hold_cnt_q  <= '0;
         stage_cnt_q <= '0;
         idx_q       <= '0;
         wdt_cnt_q   <= '0;
         rst_n_q     <= '0;
         released_q  <= 1'b0;
         fired_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         stage_cnt_q <= stage_cnt_d;
         idx_q       <= idx_d;
         wdt_cnt_q   <= wdt_cnt_d;
         rst_n_q     <= rst_n_d;
         released_q  <= released_d;
         fired_q     <= fired_d;
      end
   end

   assign o_rst_n        = rst_n_q;
   assign o_all_released = released_q;
   assign o_wdt_fired    = fired_q;
   assign o_state        = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (default and 1-channel/1-delay builds)
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_n = 1'b1;
   logic       kick = 1'b0;
   logic       wdt_en = 1'b0;
   logic [2:0] rst_a;
   logic       rel_a, fired_a;
   logic [1:0] state_a;

   logic       rst_n_b = 1'b0;
   logic       btn_n_b = 1'b1;
   logic       kick_b = 1'b0;
   logic       wdt_en_b = 1'b0;
   logic [0:0] rst_b;
   logic       rel_b, fired_b;
   logic [1:0] state_b;

   int total = 0;
   int bad = 0;
   int ed = 0;

   typedef struct {
      int          edge_no;
      int          sel;
      logic [31:0] exp;
      string       tag;
   } sb_t;
   sb_t sb[$];

   always #5 clk = ~clk;

   reset_sequencer u_dut_a (
      .i_sysclk       (clk),
      .i_rst_n        (rst_n),
      .i_button_n     (btn_n),
      .i_kick         (kick),
      .i_wdt_en       (wdt_en),
      .o_rst_n        (rst_a),
      .o_all_released (rel_a),
      .o_wdt_fired    (fired_a),
      .o_state        (state_a)
   );

   reset_sequencer #(
      .NUM_CHANNELS (1),
      .STAGE_DELAY  (1)
   ) u_dut_b (
      .i_sysclk       (clk),
      .i_rst_n        (rst_n_b),
      .i_button_n     (btn_n_b),
      .i_kick         (kick_b),
      .i_wdt_en       (wdt_en_b),
      .o_rst_n        (rst_b),
      .o_all_released (rel_b),
      .o_wdt_fired    (fired_b),
      .o_state        (state_b)
   );

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:       return 32'(rst_a);
         1:       return 32'(rel_a);
         2:       return 32'(fired_a);
         3:       return 32'(state_a);
         4:       return 32'(rst_b);
         5:       return 32'(rel_b);
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic push(input int e, input int sel, input int v, input string tag);
      sb_t s;
      s.edge_no = e;
      s.sel     = sel;
      s.exp     = 32'(v);
      s.tag     = tag;
      sb.push_back(s);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ed++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].edge_no == ed) begin
            check($sformatf("%s@%0d", sb[i].tag, ed), observe(sb[i].sel), sb[i].exp);
            sb.delete(i);
         end
      end
   endtask

   task automatic run_to(input int target);
      while (ed < target) step();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_rst_a", observe(0), 0);
      check("reset_rel_a", observe(1), 0);
      check("reset_fired_a", observe(2), 0);
      check("reset_state_a", observe(3), 0);
      check("reset_rst_b", observe(4), 0);

      rst_n   = 1'b1;
      rst_n_b = 1'b1;
      ed      = 0;

      // power-on staging, button released throughout
      push(15, 3, 0, "po_state_hold");
      push(16, 3, 1, "po_state_stage");
      push(23, 0, 0, "po_rst");
      push(24, 0, 1, "po_rst");
      push(31, 0, 1, "po_rst");
      push(32, 0, 3, "po_rst");
      push(39, 0, 3, "po_rst");
      push(39, 1, 0, "po_rel");
      push(40, 0, 7, "po_rst");
      push(40, 1, 1, "po_rel");
      push(40, 3, 2, "po_state_run");
      push(40, 2, 0, "po_fired");
      push(16, 4, 0, "b_rst");
      push(17, 4, 1, "b_rst");
      push(17, 5, 1, "b_rel");
      run_to(50);

      // 3-cycle bounce is filtered
      btn_n = 1'b0;
      repeat (3) step();
      btn_n = 1'b1;
      push(60, 0, 7, "bounce_rst");
      push(60, 1, 1, "bounce_rel");
      run_to(60);

      // 8-cycle press resets, then restages 16/8/8/8 from hold entry
      btn_n = 1'b0;
      push(66, 0, 7, "press_rst");
      push(67, 0, 0, "press_rst");
      push(67, 1, 0, "press_rel");
      push(67, 3, 0, "press_state");
      run_to(68);
      btn_n = 1'b1;
      push(82, 3, 0, "restage_state");
      push(83, 3, 1, "restage_state");
      push(90, 0, 0, "restage_rst");
      push(91, 0, 1, "restage_rst");
      push(98, 0, 1, "restage_rst");
      push(99, 0, 3, "restage_rst");
      push(106, 0, 3, "restage_rst");
      push(107, 0, 7, "restage_rst");
      push(107, 1, 1, "restage_rel");
      run_to(110);

      // kick every 63 cycles never lets the watchdog expire
      wdt_en = 1'b1;
      push(362, 0, 7, "kick_rst");
      push(362, 2, 0, "kick_fired");
      for (int n = 0; n < 4; n++) begin
         repeat (62) step();
         kick = 1'b1;
         step();
         kick = 1'b0;
      end

      // watchdog disabled, no kicks
      wdt_en = 1'b0;
      push(1362, 0, 7, "wdt_off_rst");
      push(1362, 2, 0, "wdt_off_fired");
      run_to(1362);

      // watchdog expiry and sticky flag through restaging
      wdt_en = 1'b1;
      push(1425, 0, 7, "wdt_rst");
      push(1425, 2, 0, "wdt_fired");
      push(1426, 0, 0, "wdt_rst");
      push(1426, 1, 0, "wdt_rel");
      push(1426, 2, 1, "wdt_fired");
      push(1426, 3, 0, "wdt_state");
      push(1441, 3, 0, "wdt_restage_state");
      push(1442, 3, 1, "wdt_restage_state");
      push(1450, 0, 1, "wdt_restage_rst");
      push(1450, 2, 1, "wdt_restage_fired");
      push(1458, 0, 3, "wdt_restage_rst");
      push(1466, 0, 7, "wdt_restage_rst");
      push(1466, 1, 1, "wdt_restage_rel");
      push(1466, 2, 1, "wdt_restage_fired");
      run_to(1523);

      // debounced press lands on the same cycle as the second expiry
      btn_n = 1'b0;
      push(1529, 0, 7, "simul_rst");
      push(1529, 2, 1, "simul_fired");
      push(1530, 0, 0, "simul_rst");
      push(1530, 2, 0, "simul_fired");
      push(1530, 3, 0, "simul_state");
      run_to(1530);
      btn_n = 1'b1;
      push(1545, 3, 0, "simul_restage_state");
      push(1546, 3, 1, "simul_restage_state");
      push(1554, 0, 1, "simul_restage_rst");
      run_to(1556);

      // asynchronous reset in the middle of staging
      check("midstage_rst_pre", observe(0), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", observe(0), 0);
      check("async_state", observe(3), 0);
      check("async_fired", observe(2), 0);
      check("async_rel", observe(1), 0);

      check("scoreboard_leftover", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
